design6_seq: RTL and testbench



---
 rtl/design6_seq_if.sv | 24 ++
 rtl/design6_seq.sv | 81 ++++++++
 tb/tb_design6_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/design6_seq_if.sv
// Bundle of the request/result signals of the sequential four-operand adder.
// start is a request with no ready: it is taken only when the adder is idle.
// valid is a one-cycle strobe that marks a new result on F.
interface design6_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [WIDTH+1:0] F;
  logic             valid;

  modport master (
    output start, A, B, C, D,
    input  F, valid
  );

  modport slave (
    input  start, A, B, C, D,
    output F, valid
  );
endinterface

// File: rtl/design6_seq.sv
// Sequential four-operand adder: captures A..D on start, adds one operand per
// cycle into a WIDTH+2 accumulator and strobes valid with the sum on F.
module design6_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  design6_seq_if.slave     bus,
  output logic [2:0]       fsm_state
);
  localparam int RW = WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_B = 3'd1,
    ACC_C = 3'd2,
    ACC_D = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] d_reg;
  logic [RW-1:0]    acc;
  logic [RW-1:0]    f_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = bus.start ? ACC_B : IDLE;
      ACC_B:   state_next = ACC_C;
      ACC_C:   state_next = ACC_D;
      ACC_D:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A is folded straight into the accumulator, so only B..D need holding.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg   <= '0;
      c_reg   <= '0;
      d_reg   <= '0;
      acc     <= '0;
      f_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            b_reg <= bus.B;
            c_reg <= bus.C;
            d_reg <= bus.D;
            acc   <= {2'b00, bus.A};
          end
        end
        ACC_B: acc <= acc + {2'b00, b_reg};
        ACC_C: acc <= acc + {2'b00, c_reg};
        ACC_D: begin
          f_q     <= acc + {2'b00, d_reg};
          valid_q <= 1'b1;
        end
        DONE:    valid_q <= 1'b0;
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.F     = f_q;
  assign bus.valid = valid_q;
  assign fsm_state = state;
endmodule

// File: tb/tb_design6_seq.sv
// Bench for design6_seq: directed scenarios plus random traffic, checked every
// cycle against an edge-count model of when requests are taken and complete.
module tb_design6_seq;
  localparam int WIDTH = 4;
  localparam int RW    = WIDTH + 2;

  logic       clk;
  logic       rst;
  logic [2:0] fsm_state;

  design6_seq_if #(.WIDTH(WIDTH)) bus ();

  design6_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  int            due_q[$];
  logic [RW-1:0] model_f;
  int            edge_n    = 0;
  int            free_edge = 0;
  bit            seen_rst  = 0;
  int            vcount    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
  endtask

  // Reference: a request is taken when start is seen and no earlier request
  // occupies the 5-edge window; its sum appears exactly 3 edges later.
  always begin
    logic          s_rst, s_start;
    logic [RW-1:0] sum;
    bit            exp_valid;
    @(posedge clk);
    edge_n++;
    s_rst   = rst;
    s_start = bus.start;
    sum     = RW'(bus.A) + RW'(bus.B) + RW'(bus.C) + RW'(bus.D);
    exp_valid = 0;
    if (s_rst === 1'b1) begin
      seen_rst = 1;
      exp_q.delete();
      due_q.delete();
      model_f   = '0;
      free_edge = edge_n + 1;
    end else if (seen_rst) begin
      if (s_start && edge_n >= free_edge) begin
        exp_q.push_back(sum);
        due_q.push_back(edge_n + 3);
        free_edge = edge_n + 5;
      end
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        exp_valid = 1;
        model_f   = exp_q.pop_front();
        void'(due_q.pop_front());
      end
    end
    #1;
    if (seen_rst) begin
      if (bus.valid === 1'b1) vcount++;
      check("valid", 32'(bus.valid), 32'(exp_valid));
      check("f", 32'(bus.F), 32'(model_f));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ops(input int a, input int b, input int c, input int d);
    bus.A = WIDTH'(a);
    bus.B = WIDTH'(b);
    bus.C = WIDTH'(c);
    bus.D = WIDTH'(d);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    cycles(n);
    rst = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int c, input int d);
    @(negedge clk);
    set_ops(a, b, c, d);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    rst       = 1'b0;
    bus.start = 1'b0;
    set_ops(0, 0, 0, 0);
    do_reset(2);
    #1;
    check("reset_f", 32'(bus.F), 0);
    check("reset_valid", 32'(bus.valid), 0);
    check("reset_state", 32'(fsm_state), 0);

    // basic sum
    run_op(3, 5, 7, 2);
    set_ops(0, 0, 0, 0);
    cycles(6);
    check("basic_f", 32'(bus.F), 17);

    // max operands
    run_op(15, 15, 15, 15);
    cycles(6);
    check("max_f", 32'(bus.F), 60);

    // zero operands replace previous result
    run_op(0, 0, 0, 0);
    cycles(6);
    check("zero_f", 32'(bus.F), 0);

    // busy: operands change and a second start lands in ACC_C
    v0 = vcount;
    run_op(1, 2, 3, 4);
    set_ops(9, 9, 9, 9);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles(8);
    check("busy_f", 32'(bus.F), 10);
    check("busy_nvalid", 32'(vcount - v0), 1);

    // reset mid-operation aborts the sum
    v0 = vcount;
    run_op(5, 5, 5, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cycles(6);
    check("abort_nvalid", 32'(vcount - v0), 0);
    check("abort_f", 32'(bus.F), 0);
    run_op(1, 1, 1, 1);
    cycles(6);
    check("after_abort_f", 32'(bus.F), 4);

    // start held high: a result every 5 cycles
    v0 = vcount;
    @(negedge clk);
    set_ops(2, 4, 6, 8);
    bus.start = 1'b1;
    cycles(20);
    bus.start = 1'b0;
    cycles(6);
    check("b2b_nvalid", 32'(vcount - v0), 4);
    check("b2b_f", 32'(bus.F), 20);

    // random traffic with occasional resets
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      set_ops($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
      bus.start = 1'b1;
      cycles($urandom_range(1, 7));
      bus.start = 1'b0;
      set_ops($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      cycles($urandom_range(0, 4));
    end
    cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
